// File: rtl/snake_move_controller.sv
// snake_move_controller: game-logic sequencer for a snake game. On each move
// tick it steps the head one cell in the latched direction, reads the target
// cell from the grid, and then ends the game, grows the snake, or moves it by
// writing the new head and erasing the tail. Body cells live in a circular
// position buffer. All outputs are registered.
// Optional feature macro: SNACK_RESPAWN_EN (LFSR-driven snack respawn after an eat).
module snake_move_controller #(
  parameter int MAX_LEN = 32,
  parameter int INIT_X  = 16,
  parameter int INIT_Y  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        move_tick,
  input  logic [1:0]  dir_in,
  output logic [31:0] rect_read_in,
  input  logic [3:0]  rect_read_out,
  output logic [35:0] rect_write,
  output logic        busy,
  output logic        game_over,
  output logic [7:0]  snake_len,
  output logic [7:0]  score
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [7:0]  LEN_MAX = 8'(MAX_LEN);
  localparam logic [15:0] X0 = 16'(INIT_X);
  localparam logic [15:0] Y0 = 16'(INIT_Y);

  localparam logic [3:0] F_NULL  = 4'd0;
  localparam logic [3:0] F_SNAKE = 4'd1;
  localparam logic [3:0] F_ROCK  = 4'd2;
  localparam logic [3:0] F_SNACK = 4'd4;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;

  typedef enum logic [3:0] {
    IDLE, INIT_WR, READY, CALC, RD_ADDR, RD_CHK, WR_HEAD, ER_TAIL, GAME_OVER
`ifdef SNACK_RESPAWN_EN
    , RESPAWN_RD, RESPAWN_CHK, RESPAWN_WR
`endif
  } state_t;

  state_t state, next_state;

  logic [1:0]    dir;
  logic [15:0]   head_x, head_y;
  logic [15:0]   next_x, next_y;
  logic [15:0]   step_x, step_y;
  logic          grow;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   pos_buf [MAX_LEN];
  logic [31:0]   tail;
  logic          push_en;
  logic [PW-1:0] push_addr;
  logic [31:0]   push_data;
  logic          out_of_range, collide, is_snack, grow_now;

`ifdef SNACK_RESPAWN_EN
  logic [15:0] lfsr;
  logic [15:0] cand_x, cand_y;
  logic [3:0]  attempts;
  logic        ate;
  logic [4:0]  lx, ly, rx, ry;
  logic [15:0] rnd_x, rnd_y;

  // Candidate snack cell folded into the playable interior from the LFSR
  always_comb begin
    lx    = lfsr[4:0];
    ly    = lfsr[9:5];
    rx    = (lx >= 5'd30) ? lx - 5'd30 : lx;
    ry    = (ly >= 5'd22) ? ly - 5'd22 : ly;
    rnd_x = 16'd2 + {11'd0, rx};
    rnd_y = 16'd1 + {11'd0, ry};
  end

  // Free-running Fibonacci LFSR, taps 16/14/13/11
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`endif

  // Read-result decode and bounds check used in RD_CHK
  assign out_of_range = (next_x < 16'd1) || (next_x > 16'd32) || (next_y > 16'd23);
  assign collide      = (rect_read_out == F_SNAKE) || (rect_read_out == F_ROCK);
  assign is_snack     = (rect_read_out == F_SNACK);
  assign grow_now     = is_snack && (snake_len < LEN_MAX);
  assign tail         = pos_buf[rd_ptr];

  // Candidate head one cell away from the current head in the latched direction
  always_comb begin
    step_x = head_x;
    step_y = head_y;
    case (dir)
      DIR_RIGHT: step_x = head_x + 16'd1;
      DIR_DOWN:  step_y = head_y + 16'd1;
      DIR_LEFT:  step_x = head_x - 16'd1;
      default:   step_y = head_y - 16'd1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    next_state = state;
    case (state)
      IDLE, GAME_OVER: if (start) next_state = INIT_WR;
      INIT_WR:         next_state = READY;
      READY:           if (move_tick) next_state = CALC;
      CALC:            next_state = RD_ADDR;
      RD_ADDR:         next_state = RD_CHK;
      RD_CHK:          next_state = (out_of_range || collide) ? GAME_OVER : WR_HEAD;
`ifdef SNACK_RESPAWN_EN
      WR_HEAD:         next_state = grow ? RESPAWN_RD : ER_TAIL;
      ER_TAIL:         next_state = ate ? RESPAWN_RD : READY;
      RESPAWN_RD:      next_state = RESPAWN_CHK;
      RESPAWN_CHK:     if (rect_read_out == F_NULL)  next_state = RESPAWN_WR;
                       else if (attempts == 4'd15)   next_state = READY;
                       else                          next_state = RESPAWN_RD;
      RESPAWN_WR:      next_state = READY;
`else
      WR_HEAD:         next_state = grow ? READY : ER_TAIL;
      ER_TAIL:         next_state = READY;
`endif
      default:         next_state = IDLE;
    endcase
  end

  // Body buffer push: the initial head on start, the new head on a move
  always_comb begin
    push_en   = 1'b0;
    push_addr = wr_ptr;
    push_data = {next_x, next_y};
    if (next_state == INIT_WR) begin
      push_en   = 1'b1;
      push_addr = '0;
      push_data = {X0, Y0};
    end else if (state == RD_CHK && next_state == WR_HEAD) begin
      push_en = 1'b1;
    end
  end

  // Body position storage
  // NOTE: storage array is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) pos_buf[push_addr] <= push_data;
  end

  // Registered outputs and datapath, keyed on the transition being taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rect_write   <= '0;
      rect_read_in <= '0;
      busy         <= 1'b0;
      game_over    <= 1'b0;
      snake_len    <= '0;
      score        <= '0;
      dir          <= DIR_RIGHT;
      head_x       <= '0;
      head_y       <= '0;
      next_x       <= '0;
      next_y       <= '0;
      grow         <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
`ifdef SNACK_RESPAWN_EN
      cand_x       <= '0;
      cand_y       <= '0;
      attempts     <= '0;
      ate          <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every read sees the pre-edge value.
      busy      <= !(next_state inside {IDLE, READY, GAME_OVER});
      game_over <= (next_state == GAME_OVER);

      // Direction is sampled every READY cycle; an instant reversal is refused once the body has length
      if (state == READY && !(snake_len > 8'd1 && dir_in == (dir ^ 2'd2)))
        dir <= dir_in;

      if (next_state == INIT_WR) begin
        rect_write <= {X0, Y0, F_SNAKE};
        head_x     <= X0;
        head_y     <= Y0;
        wr_ptr     <= PTR_ONE;
        rd_ptr     <= '0;
        snake_len  <= 8'd1;
        score      <= 8'd0;
        dir        <= DIR_RIGHT;
      end

      if (state == CALC) begin
        next_x       <= step_x;
        next_y       <= step_y;
        rect_read_in <= {step_x, step_y};
      end

      if (state == RD_CHK && next_state == WR_HEAD) begin
        grow       <= grow_now;
        rect_write <= {next_x, next_y, F_SNAKE};
        head_x     <= next_x;
        head_y     <= next_y;
        wr_ptr     <= wr_ptr + PTR_ONE;
        if (grow_now)                      snake_len <= snake_len + 8'd1;
        if (is_snack && score != 8'hFF)    score     <= score + 8'd1;
`ifdef SNACK_RESPAWN_EN
        ate        <= is_snack;
`endif
      end

      if (next_state == ER_TAIL) begin
        rect_write <= {tail, F_NULL};
        rd_ptr     <= rd_ptr + PTR_ONE;
      end

`ifdef SNACK_RESPAWN_EN
      if (next_state == RESPAWN_RD) begin
        cand_x       <= rnd_x;
        cand_y       <= rnd_y;
        rect_read_in <= {rnd_x, rnd_y};
        attempts     <= (state == RESPAWN_CHK) ? attempts + 4'd1 : 4'd0;
      end
      if (next_state == RESPAWN_WR) rect_write <= {cand_x, cand_y, F_SNACK};
`endif
    end
  end

endmodule

// File: tb/tb_snake_move_controller.sv
// Directed bench for snake_move_controller: a table of single moves through one
// game, followed by hand-written sequences for game-over hold, restart, the
// right-hand grid boundary, self collision and asynchronous reset mid-move.
module tb_snake_move_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        move_tick = 1'b0;
  logic [1:0]  dir_in = 2'd0;
  logic [31:0] rect_read_in;
  logic [3:0]  rect_read_out;
  logic [35:0] rect_write;
  logic        busy, game_over;
  logic [7:0]  snake_len, score;

  // Grid stand-in: one target cell answers with a chosen code, everything else is NULL
  logic [15:0] tgt_x = 16'd0, tgt_y = 16'd0;
  logic [3:0]  tgt_code = 4'd0;
  assign rect_read_out = (rect_read_in == {tgt_x, tgt_y}) ? tgt_code : 4'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  snake_move_controller dut (
    .clk(clk), .rst(rst), .start(start), .move_tick(move_tick), .dir_in(dir_in),
    .rect_read_in(rect_read_in), .rect_read_out(rect_read_out), .rect_write(rect_write),
    .busy(busy), .game_over(game_over), .snake_len(snake_len), .score(score)
  );

  typedef struct {
    logic [1:0]  dir;
    logic [3:0]  code;
    logic [15:0] hx, hy;   // expected new head / read address
    logic        tail;     // tail erase expected
    logic [15:0] tx, ty;   // tail cell, or held write cell on game over
    int          len;
    int          scr;
    int          busy_cycles;
    logic        go;
  } vec_t;

  vec_t vecs [7];

  logic [35:0] wr_tr [7];
  logic [31:0] rd_tr [7];
  int          busy_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start and check the initial head write one clock later
  task automatic start_game(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_init_wr"}, rect_write, {16'd16, 16'd12, 4'd1});
    check({tag, "_init_len"}, snake_len, 8'd1);
    check({tag, "_init_score"}, score, 8'd0);
    check({tag, "_init_go"}, game_over, 1'b0);
    @(posedge clk); #1;
    check({tag, "_ready_busy"}, busy, 1'b0);
  endtask

  // One move tick; records rect_write / rect_read_in after each of 7 edges
  task automatic do_move(input logic [1:0] d);
    @(negedge clk);
    dir_in    = d;
    move_tick = 1'b1;
    busy_cnt  = 0;
    for (int e = 0; e < 7; e++) begin
      @(posedge clk); #1;
      if (e == 0) move_tick = 1'b0;
      wr_tr[e] = rect_write;
      rd_tr[e] = rect_read_in;
      if (busy) busy_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          dir   code  hx      hy      tail  tx      ty      len scr busy go
    vecs[0] = '{2'd0, 4'd0, 16'd17, 16'd12, 1'b1, 16'd16, 16'd12, 1,  0,  5,   1'b0};
    vecs[1] = '{2'd2, 4'd0, 16'd16, 16'd12, 1'b1, 16'd17, 16'd12, 1,  0,  5,   1'b0};
    vecs[2] = '{2'd0, 4'd4, 16'd17, 16'd12, 1'b0, 16'd0,  16'd0,  2,  1,  4,   1'b0};
    vecs[3] = '{2'd2, 4'd0, 16'd18, 16'd12, 1'b1, 16'd16, 16'd12, 2,  1,  5,   1'b0};
    vecs[4] = '{2'd0, 4'd4, 16'd19, 16'd12, 1'b0, 16'd0,  16'd0,  3,  2,  4,   1'b0};
    vecs[5] = '{2'd2, 4'd0, 16'd20, 16'd12, 1'b1, 16'd17, 16'd12, 3,  2,  5,   1'b0};
    vecs[6] = '{2'd0, 4'd2, 16'd21, 16'd12, 1'b0, 16'd17, 16'd12, 3,  2,  3,   1'b1};

    // Reset state
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write", rect_write, 36'd0);
    check("rst_read", rect_read_in, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_go", game_over, 1'b0);
    check("rst_len", snake_len, 8'd0);
    check("rst_score", score, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 1'b0);

    // Table-driven moves through one game
    start_game("g1");
    for (int i = 0; i < 7; i++) begin
      tgt_x    = vecs[i].hx;
      tgt_y    = vecs[i].hy;
      tgt_code = vecs[i].code;
      do_move(vecs[i].dir);
      check($sformatf("v%0d_rd_addr", i), rd_tr[1], {vecs[i].hx, vecs[i].hy});
      check($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].busy_cycles);
      check($sformatf("v%0d_len", i), snake_len, vecs[i].len[7:0]);
      check($sformatf("v%0d_score", i), score, vecs[i].scr[7:0]);
      check($sformatf("v%0d_go", i), game_over, vecs[i].go);
      if (vecs[i].go) begin
        check($sformatf("v%0d_held_wr", i), wr_tr[6], {vecs[i].tx, vecs[i].ty, 4'd0});
      end else begin
        check($sformatf("v%0d_head_wr", i), wr_tr[3], {vecs[i].hx, vecs[i].hy, 4'd1});
        if (vecs[i].tail)
          check($sformatf("v%0d_tail_wr", i), wr_tr[4], {vecs[i].tx, vecs[i].ty, 4'd0});
        else
          check($sformatf("v%0d_no_tail", i), wr_tr[4], {vecs[i].hx, vecs[i].hy, 4'd1});
      end
    end

    // Game over: move_tick is dropped, nothing moves
    do_move(2'd0);
    check("go_tick_busy", busy_cnt, 0);
    check("go_tick_hold", wr_tr[6], {16'd17, 16'd12, 4'd0});
    check("go_tick_go", game_over, 1'b1);

    // Restart clears score and length; walk right to the last column, then off the grid
    start_game("g2");
    for (int x = 17; x <= 32; x++) begin
      tgt_x    = x[15:0];
      tgt_y    = 16'd12;
      tgt_code = 4'd0;
      do_move(2'd0);
      check($sformatf("walk_head_%0d", x), wr_tr[3], {x[15:0], 16'd12, 4'd1});
    end
    check("walk_go_before_edge", game_over, 1'b0);
    tgt_x = 16'd33;
    do_move(2'd0);
    check("edge_rd_addr", rd_tr[1], {16'd33, 16'd12});
    check("edge_go", game_over, 1'b1);
    check("edge_busy_cycles", busy_cnt, 3);
    check("edge_held_wr", wr_tr[6], {16'd31, 16'd12, 4'd0});

    // Self collision: target reads SNAKE
    start_game("g3");
    tgt_x    = 16'd17;
    tgt_y    = 16'd12;
    tgt_code = 4'd1;
    do_move(2'd0);
    check("self_go", game_over, 1'b1);
    check("self_len", snake_len, 8'd1);
    check("self_held_wr", wr_tr[6], {16'd16, 16'd12, 4'd1});

    // Asynchronous reset while in RD_CHK
    start_game("g4");
    tgt_code = 4'd0;
    @(negedge clk);
    dir_in    = 2'd0;
    move_tick = 1'b1;
    @(posedge clk); #1;
    move_tick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_write", rect_write, 36'd0);
    check("arst_read", rect_read_in, 32'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_len", snake_len, 8'd0);
    check("arst_score", score, 8'd0);
    check("arst_go", game_over, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    start_game("g5");
    tgt_x = 16'd17;
    do_move(2'd0);
    check("post_rst_head", wr_tr[3], {16'd17, 16'd12, 4'd1});
    check("post_rst_tail", wr_tr[4], {16'd16, 16'd12, 4'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snake_move_controller.md
Name: snake_move_controller

Overview:
- Game-logic sequencer that owns the grid register's read port (rect_read_in/rect_read_out) and its write port (rect_write).
- On each move tick it computes the next head cell, reads that cell, and decides collision, eat or move. It then writes the new SNAKE head and erases the tail through the grid's write port.
- It keeps the snake body in an internal circular position buffer.
- It sits between the input/timing logic (direction, tick) and grid_register.

Parameters:
- MAX_LEN, 32, depth of the body position buffer and maximum snake length (power of 2).
- INIT_X, 16, head x cell after start (grid x range 1..32).
- INIT_Y, 12, head y cell after start (grid y range 0..23).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a game from IDLE or GAME_OVER
- move_tick  in  1  one-cycle pulse; request one snake step
- dir_in  in  2  requested direction: 0=right 1=down 2=left 3=up
- rect_read_in  out  32  {x[15:0], y[15:0]} read address to grid
- rect_read_out  in  4  cell function from grid (combinational off rect_read_in): NULL=0 SNAKE=1 ROCK=2 SNACK=4
- rect_write  out  36  {x[15:0], y[15:0], function[3:0]} to grid; the grid writes it every cycle
- busy  out  1  high in any state other than IDLE, READY and GAME_OVER
- game_over  out  1  high in GAME_OVER
- snake_len  out  8  current length
- score  out  8  snacks eaten, saturating at 255

Behaviour:
- Reset values:
  - rect_write = {16'd0, 16'd0, 4'd0}. Grid index 0 is unused, so this write is harmless.
  - rect_read_in = 0, busy = 0, game_over = 0, snake_len = 0, score = 0.
  - dir = right, buffer pointers = 0, state = IDLE.
- All outputs are registered.
- rect_write holds its last value between writes. Rewriting the same cell with the same value is idempotent, so no write enable is needed.
- States: IDLE, INIT_WR, READY, CALC, RD_ADDR, RD_CHK, WR_HEAD, ER_TAIL, GAME_OVER.
- IDLE/GAME_OVER + start -> INIT_WR:
  - rect_write = {INIT_X, INIT_Y, SNAKE}; push the head into the buffer.
  - snake_len = 1, score = 0, dir = right, game_over = 0.
  - Next state is READY.
- Old-game cleanup: cells from the previous game are not cleared by this block. The grid must be reset externally before start.
- Direction latch: sampled in READY on every cycle.
  - A request that is the exact reverse of the current dir is ignored while snake_len > 1.
- READY + move_tick -> CALC. move_tick in any other state is dropped.
- CALC: next = head ±1 in x or y, 16-bit unsigned. Next state RD_ADDR.
- RD_ADDR: drive rect_read_in = {next_x, next_y}. The value is sampled one cycle later, in RD_CHK.
- RD_CHK decisions:
  - ROCK or SNAKE -> GAME_OVER. This includes the current tail cell, which is treated as a collision.
  - next_x outside 1..32 or next_y outside 0..23 -> GAME_OVER. This is checked before the read result.
  - SNACK with snake_len < MAX_LEN -> grow = 1; score +1 (saturating).
  - SNACK with snake_len == MAX_LEN -> grow = 0, score still +1.
  - NULL or any other code -> grow = 0.
- WR_HEAD: rect_write = {next, SNAKE}; push next into the buffer; head = next.
  - grow = 1: snake_len +1, then go to READY (or RESPAWN with the optional feature).
  - grow = 0: go to ER_TAIL.
- ER_TAIL: rect_write = {tail, NULL}; pop the tail; snake_len unchanged. Next state READY.
- Latency: move_tick to head write landing in the grid is 5 clk. Tail erase lands 1 clk later.
- Buffer: write and read pointers wrap modulo MAX_LEN. The same-cycle push+pop case cannot occur, because push (WR_HEAD) and pop (ER_TAIL) are in separate states.
- GAME_OVER: holds until start; rect_write holds.
- Asynchronous reset at any point returns all outputs to their reset values immediately. Grid contents are not touched.

Optional Feature:
- Macro SNACK_RESPAWN_EN.
- When defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) steps every clk.
  - After any eat, the sequence WR_HEAD -> RESPAWN_RD -> RESPAWN_CHK runs.
  - Candidate cell: x = 2 + (lfsr[4:0] mod 30), y = 1 + (lfsr[9:5] mod 22).
  - If the read is NULL, go to RESPAWN_WR: rect_write = {cand, SNACK}, then READY.
  - Otherwise retry with the next LFSR value, up to 16 attempts. After the 16th failed attempt, go to READY with no snack placed.
  - busy stays high throughout.
- When not defined: no new snack is placed and the respawn states do not exist.

Test Plan:
- Reset then start -> after 1 clk rect_write = {16, 12, 1}, snake_len = 1, busy low in READY.
- move_tick with dir = right and a NULL read -> rect_write = {17, 12, 1} in WR_HEAD, then {16, 12, 0} in ER_TAIL; len stays 1; busy high exactly 5 clk.
- Snack at (17,12) with dir = right -> no ER_TAIL; snake_len = 2, score = 1. With SNACK_RESPAWN_EN, the next write is a SNACK at a cell that read NULL.
- Head at (31,12), dir = right, grid returns ROCK -> game_over = 1, no write issued, move_tick then ignored; start restarts with score = 0.
- snake_len = 3 moving right, dir_in = left -> dir unchanged, next head x+1. With len = 1 the same request turns left.
- rst asserted during RD_CHK -> all outputs at reset values asynchronously; start after release works normally.
